// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return 30 - off_w(words) - idx_w(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: async read by index, one data-word write, one tag write.
module icache_array
    import icache_pkg::*;
#(
    parameter  int LINES = 16,
    parameter  int WORDS = 4,
    localparam int OB    = off_w(WORDS),
    localparam int IB    = idx_w(LINES),
    localparam int TB    = tag_w(LINES, WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [IB-1:0] rd_idx,
    input  logic [OB-1:0] rd_off,
    output logic          rd_valid,
    output logic [TB-1:0] rd_tag,
    output logic [31:0]   rd_data,
    input  logic [IB-1:0] wr_idx,
    input  logic [OB-1:0] wr_off,
    input  logic          data_we,
    input  logic [31:0]   wr_data,
    input  logic          tag_we,
    input  logic [TB-1:0] wr_tag
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TB-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    // A clear wins over a same-cycle validate.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (tag_we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (data_we) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped I-cache: zero-latency hit, stall and line refill on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        inv,
    output logic [31:0] instrF,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OB = off_w(WORDS);
    localparam int IB = idx_w(LINES);
    localparam int TB = tag_w(LINES, WORDS);
    localparam int LB = TB + IB;

    icache_state_t state_q, state_d;
    logic [OB-1:0] cnt_q, cnt_d;
    logic [LB-1:0] line_q, line_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;

    logic [OB-1:0] off;
    logic [IB-1:0] idx;
    logic [TB-1:0] tag;
    logic [OB-1:0] cnt_inc;
    logic          rd_valid;
    logic [TB-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          hit;
    logic          data_we;
    logic          tag_we;
    logic          unused_pc;

    assign off       = pcF[2 +: OB];
    assign idx       = pcF[2+OB +: IB];
    assign tag       = pcF[31 -: TB];
    assign unused_pc = ^pcF[1:0];
    assign cnt_inc   = cnt_q + OB'(1);
    assign hit       = rd_valid & (rd_tag == tag) & ~inv;

    icache_array #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (inv),
        .rd_idx  (idx),
        .rd_off  (off),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_idx  (line_q[IB-1:0]),
        .wr_off  (cnt_q),
        .data_we (data_we),
        .wr_data (mem_rdata),
        .tag_we  (tag_we),
        .wr_tag  (line_q[LB-1:IB])
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        instrF       = 32'h0;
        icache_stall = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    instrF       = rd_data;
                    icache_stall = 1'b0;
                end else if (!inv) begin
                    state_d    = REFILL;
                    line_d     = pcF[31:2+OB];
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pcF[31:2+OB], {OB{1'b0}}, 2'b00};
                end
            end
            REFILL: begin
                // An invalidate aborts the refill and drops any same-cycle ack.
                if (inv) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                end else if (mem_ack) begin
                    data_we    = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = {line_q, cnt_inc, 2'b00};
                    if (cnt_q == OB'(WORDS-1)) begin
                        tag_we    = 1'b1;
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches against a handshaked memory model.
module tb_icache;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcF = 32'h0;
    logic        inv = 1'b1;
    logic [31:0] instrF;
    logic        icache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;
    int ack_period = 1;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];

    icache #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcF         (pcF),
        .inv         (inv),
        .instrF      (instrF),
        .icache_stall(icache_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: ack once every ack_period cycles while a request is up.
    initial begin
        int w;
        w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset && mem_req) begin
                w++;
                if (w >= ack_period) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memword(mem_addr);
                    w         = 0;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = 1'b0;
                w       = 0;
            end
        end
    end

    // Monitor: compare every accepted request and every delivered instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mem_req && mem_ack) begin
                    if (exp_addr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL mem_addr: unexpected request %h", mem_addr);
                    end else begin
                        check("mem_addr", mem_addr, exp_addr.pop_front());
                    end
                end
                if (!icache_stall && exp_instr.size() != 0) begin
                    check("instrF", instrF, exp_instr.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < WORDS; i++) begin
            exp_addr.push_back((a & ~32'hF) + 32'(4 * i));
        end
    endtask

    task automatic wait_hit(output int n);
        n = 0;
        @(negedge clk);
        while (icache_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_fetch(input logic [31:0] a, input int exp_stall,
                             input bit refill);
        int n;
        @(posedge clk);
        #1;
        pcF = a;
        inv = 1'b0;
        if (refill) push_line(a);
        exp_instr.push_back(memword(a));
        wait_hit(n);
        check("stall cycles", 32'(n), 32'(exp_stall));
        check("mem_req on hit", {31'b0, mem_req}, 32'h0);
    endtask

    initial begin
        int n;
        #12;
        check("reset mem_req", {31'b0, mem_req}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset stall", {31'b0, icache_stall}, 32'h1);
        check("reset instrF", instrF, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Cold miss, then hits across the line.
        run_fetch(32'h40, 5, 1'b1);
        run_fetch(32'h44, 0, 1'b0);
        run_fetch(32'h48, 0, 1'b0);
        run_fetch(32'h4C, 0, 1'b0);

        // Conflict on index 4.
        run_fetch(32'h440, 5, 1'b1);
        run_fetch(32'h40, 5, 1'b1);
        run_fetch(32'h44, 0, 1'b0);

        // Slow memory.
        ack_period = 3;
        run_fetch(32'h80, 13, 1'b1);
        run_fetch(32'h8C, 0, 1'b0);
        ack_period = 1;

        // Invalidate while idle.
        @(posedge clk);
        #1;
        pcF = 32'h44;
        inv = 1'b1;
        @(negedge clk);
        check("inv idle stall", {31'b0, icache_stall}, 32'h1);
        check("inv idle instrF", instrF, 32'h0);
        run_fetch(32'h40, 5, 1'b1);
        run_fetch(32'h80, 5, 1'b1);

        // Invalidate after the second ack aborts the refill.
        @(posedge clk);
        #1;
        pcF = 32'hC0;
        inv = 1'b0;
        exp_addr.push_back(32'hC0);
        exp_addr.push_back(32'hC4);
        exp_addr.push_back(32'hC8);
        @(negedge clk);
        check("abort detect stall", {31'b0, icache_stall}, 32'h1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        @(negedge clk);
        check("abort mem_req", {31'b0, mem_req}, 32'h0);
        check("abort line invalid", {31'b0, icache_stall}, 32'h1);
        push_line(32'hC0);
        exp_instr.push_back(memword(32'hC0));
        wait_hit(n);
        check("refill after abort", 32'(n), 32'd4);

        // Reset in the middle of a slow refill.
        ack_period = 3;
        @(posedge clk);
        #1;
        pcF = 32'h100;
        exp_addr.push_back(32'h100);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        inv   = 1'b1;
        #1;
        check("midreset mem_req", {31'b0, mem_req}, 32'h0);
        check("midreset mem_addr", mem_addr, 32'h0);
        check("midreset stall", {31'b0, icache_stall}, 32'h1);
        check("midreset instrF", instrF, 32'h0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        ack_period = 1;
        run_fetch(32'h100, 5, 1'b1);
        run_fetch(32'h40, 5, 1'b1);
        run_fetch(32'h4C, 0, 1'b0);

        repeat (2) @(negedge clk);
        check("addr queue drained", 32'(exp_addr.size()), 32'h0);
        check("instr queue drained", 32'(exp_instr.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch-stage PC register and a slow, handshaked instruction memory. It returns `instrF` on a hit in the same cycle. On a miss it raises `icache_stall`, which the hazard unit ORs into `stallF`/`stallD`. It then refills the whole line one word per memory acknowledge and resumes.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `pcF` input 32: fetch address; bits [1:0] ignored.
- `inv` input 1: invalidate-all request, one-cycle pulse.
- `instrF` output 32: fetched instruction.
- `icache_stall` output 1: fetch must hold `pcF`.
- `mem_req` output 1: memory word request.
- `mem_addr` output 32: word address of the request; bits [1:0] = 0.
- `mem_ack` input 1: `mem_rdata` is valid this cycle.
- `mem_rdata` input 32: returned word.

## Operation
- Address split:
  - offset = `pcF[2+OB-1:2]`, with OB = log2(WORDS).
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Per-line storage: valid bit, tag, WORDS data words.
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = valid[index] & tag match & ~`inv`.
  - On a hit: `instrF` = data[index][offset], `icache_stall` = 0.
  - On a miss: `icache_stall` = 1 and `instrF` = 32'h0 (NOP bubble). `pcF[31:2+OB]` is latched as the miss line address, the word counter is cleared, and the FSM goes to REFILL.
- REFILL:
  - `mem_req` = 1, `mem_addr` = {latched line address, counter, 2'b00}, `icache_stall` = 1, `instrF` = 0.
  - Each cycle with `mem_ack`: write `mem_rdata` into data[latched index][counter] and increment the counter.
  - On the ack of word WORDS-1: set valid and write the tag for the latched index, then go to IDLE.
  - The next cycle looks up the current `pcF` normally, which hits if `pcF` was held.
- `mem_ack` while in IDLE is ignored.
- `inv`:
  - All valid bits clear at the next edge.
  - In IDLE, `inv` forces a miss indication with `icache_stall` = 1, but no refill starts that cycle.
  - In REFILL, `inv` aborts: go to IDLE, line not validated, `mem_req` deasserts the next cycle. An ack arriving in the same cycle as `inv` is discarded.
- Refill always uses the latched address. Changes on `pcF` during REFILL are ignored.

## Timing
- Reset values:
  - state = IDLE, all valid = 0, counter = 0, latched address = 0.
  - `mem_req` = 0, `mem_addr` = 0.
  - `icache_stall` = 1 while reset is asserted only if `pcF` misses. Since all lines are invalid, this means 1 after reset.
  - `instrF` = 0.
- Hit latency is 0 cycles: combinational from `pcF`.
- Miss penalty = 1 (detect cycle) + the cycles until WORDS acks are received + 0. With a zero-wait memory (ack every cycle), `icache_stall` is high for WORDS+1 cycles.
- Handshake:
  - `mem_req` and `mem_addr` are registered and stay stable until `mem_ack`.
  - `mem_addr` advances on the edge after each ack.
  - At most one ack per cycle; no outstanding requests after `mem_req` falls.
- Reset mid-REFILL: immediate return to IDLE, with all outputs at their reset values asynchronously.

## Structure
- Package `icache_pkg`:
  - `icache_state_t` enum {IDLE, REFILL}.
  - Width helper functions (offset, index and tag widths from LINES/WORDS).
- Sub-module `icache_array`:
  - Storage for the valid/tag/data arrays.
  - Async read by index.
  - One synchronous write port for a data word.
  - A separate tag/valid write.
  - A global valid clear, asynchronous on reset and synchronous on `inv`.
- Top `icache` holds the FSM, counter, latched address and output muxing.

## Test plan
- **Cold miss:** after reset, `pcF` = 0x0000_0040 with ack every cycle. Expect `mem_addr` 0x40, 0x44, 0x48, 0x4C on consecutive cycles and `icache_stall` high for 5 cycles; the next cycle hits with `instrF` = the word returned for 0x40.
- **Line hit:** after the refill, step `pcF` through 0x44, 0x48, 0x4C. Expect `icache_stall` = 0 and the matching data each cycle, with `mem_req` = 0.
- **Conflict miss:** with LINES=16 and WORDS=4, `pcF` = 0x0000_0440 (same index, new tag). Expect a refill from 0x440; a later access to 0x40 misses again.
- **Slow memory:** ack every 3rd cycle. Expect `mem_addr` held for 3 cycles per word and a stall of 1 + 12 cycles.
- **Invalidate:** `inv` pulse in IDLE, then `pcF` = 0x40. Expect a miss and refill. Also pulse `inv` after the second ack of a refill: expect abort, `mem_req` low the next cycle, and the line not valid afterwards.
- **Reset mid-refill:** assert reset during REFILL. Expect `mem_req` = 0 immediately, all lines invalid, state IDLE.
